seq_bit_serializer: RTL and testbench

- Upstream feeder for the 1010 sequence detector.
- Accepts parallel words through a valid/ready handshake and shifts them out one bit per clock on x_out, which drives the detector's serial input x.
- Also provides bit_valid, busy and last_bit so downstream logic can qualify the stream.
- Supports gapless back-to-back words, so patterns that span a word boundary still reach the detector intact.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_bit_counter.sv | 30 +++
 rtl/seq_bit_serializer.sv | 131 +++++++++++++
 tb/tb_seq_bit_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serializer and the 1010 sequence detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef enum logic [1:0] {
        DET_S0    = 2'd0,
        DET_S1    = 2'd1,
        DET_S10   = 2'd2,
        DET_S101  = 2'd3
    } det_state_t;

    localparam logic IDLE_BIT = 1'b0;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Down-counter with load, decrement and zero flag; load wins over decrement.
module seq_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_r;

    // Count register; decrement holds at zero so the count never underflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CW{1'b0}})) begin
            count_r <= count_r - CW'(1);
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {CW{1'b0}});

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1010 detector, gapless back-to-back words.
// Optional macro SER_PARITY_EN appends an even-parity bit to every word.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             last_bit
);

`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
        $error("seq_bit_serializer: WIDTH must be in 2..32");
    end

    ser_state_t       state_r, state_nx_s;
    logic [NBITS-2:0] shreg_r, shreg_nx_s;
    logic [NBITS-1:0] frame_s;
    logic             x_out_r, x_nx_s;
    logic             bit_valid_r, bv_nx_s;
    logic             last_bit_r, last_nx_s;
    logic             accept_s;
    logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
    logic [CW-1:0]    cnt_val_s;

    seq_bit_counter #(.CW(CW)) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (CW'(NBITS - 1)),
        .dec      (cnt_dec_s),
        .count    (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    assign load_ready = rst && ((state_r == IDLE) || ((state_r == SHIFT) && last_bit_r));
    assign accept_s   = load_valid && load_ready;

    // Frame the word so the first bit to transmit sits at frame_s[NBITS-1].
    always_comb begin
        frame_s = {NBITS{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                frame_s[NBITS-1-i] = data_in[WIDTH-1-i];
            end else begin
                frame_s[NBITS-1-i] = data_in[i];
            end
        end
`ifdef SER_PARITY_EN
        frame_s[0] = even_parity(32'(data_in));
`endif
    end

    // Next-state and next-output logic for the IDLE/SHIFT machine.
    always_comb begin
        state_nx_s = state_r;
        shreg_nx_s = shreg_r;
        x_nx_s     = x_out_r;
        bv_nx_s    = bit_valid_r;
        last_nx_s  = last_bit_r;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_r)
            IDLE, SHIFT: begin
                if (accept_s) begin
                    state_nx_s = SHIFT;
                    x_nx_s     = frame_s[NBITS-1];
                    shreg_nx_s = frame_s[NBITS-2:0];
                    bv_nx_s    = 1'b1;
                    last_nx_s  = 1'b0;
                    cnt_load_s = 1'b1;
                end else if ((state_r == IDLE) || cnt_zero_s) begin
                    state_nx_s = IDLE;
                    x_nx_s     = IDLE_LEVEL;
                    bv_nx_s    = 1'b0;
                    last_nx_s  = 1'b0;
                end else begin
                    x_nx_s     = shreg_r[NBITS-2];
                    shreg_nx_s = shreg_r << 1;
                    cnt_dec_s  = 1'b1;
                    last_nx_s  = (cnt_val_s == CW'(1));
                end
            end
            default: begin
                state_nx_s = IDLE;
                x_nx_s     = IDLE_LEVEL;
                bv_nx_s    = 1'b0;
                last_nx_s  = 1'b0;
            end
        endcase
    end

    // State, shift register and registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            shreg_r     <= {(NBITS-1){1'b0}};
            x_out_r     <= IDLE_LEVEL;
            bit_valid_r <= 1'b0;
            last_bit_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            shreg_r     <= shreg_nx_s;
            x_out_r     <= x_nx_s;
            bit_valid_r <= bv_nx_s;
            last_bit_r  <= last_nx_s;
        end
    end

    assign x_out     = x_out_r;
    assign bit_valid = bit_valid_r;
    assign busy      = bit_valid_r;
    assign last_bit  = last_bit_r;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomized bench for seq_bit_serializer against a queue-based bit-stream model.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int PAR      = 1;
    localparam int HITS_EXP = 2;
`else
    localparam int PAR      = 0;
    localparam int HITS_EXP = 3;
`endif
    localparam int   FL8  = 8 + PAR;
    localparam int   FL4  = 4 + PAR;
    localparam logic IDLE = 1'b0;

    logic       clk, rst;
    logic [7:0] d8_data;
    logic       d8_valid, d8_ready, d8_x, d8_bv, d8_busy, d8_last;
    logic [3:0] d4_data;
    logic       d4_valid, d4_ready, d4_x, d4_bv, d4_busy, d4_last;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    bit q_bit[$];
    bit q_last[$];
    bit obs[$];

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
        .clk(clk), .rst(rst), .data_in(d8_data), .load_valid(d8_valid),
        .load_ready(d8_ready), .x_out(d8_x), .bit_valid(d8_bv),
        .busy(d8_busy), .last_bit(d8_last)
    );

    seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .data_in(d4_data), .load_valid(d4_valid),
        .load_ready(d4_ready), .x_out(d4_x), .bit_valid(d4_bv),
        .busy(d4_busy), .last_bit(d4_last)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit idx of the transmitted frame for a word, straight from the bit-order rules.
    function automatic bit frame_bit(input logic [31:0] word, input int w, input bit msb, input int idx);
        logic [31:0] m;
        if (idx < w) return msb ? word[w-1-idx] : word[idx];
        m = word & ((32'h1 << w) - 32'h1);
        return ^m;
    endfunction

    function automatic bit model_ready();
        return rst && ((q_bit.size() == 0) || q_last[0]);
    endfunction

    task automatic check_outputs();
        bit ex, ev, el;
        ex = IDLE; ev = 1'b0; el = 1'b0;
        if (q_bit.size() > 0) begin
            ex = q_bit[0]; ev = 1'b1; el = q_last[0];
        end
        check_val("x_out", 32'(d8_x), 32'(ex));
        check_val("bit_valid", 32'(d8_bv), 32'(ev));
        check_val("busy", 32'(d8_busy), 32'(ev));
        check_val("last_bit", 32'(d8_last), 32'(el));
        check_val("load_ready", 32'(d8_ready), 32'(model_ready()));
        if (d8_bv) obs.push_back(d8_x);
    endtask

    // One clock on dut8: drive in the low phase, update the model at the edge, check after.
    task automatic step(input bit v, input logic [7:0] d);
        bit acc;
        d8_valid = v;
        d8_data  = d;
        acc = v && model_ready();
        @(posedge clk);
        if (q_bit.size() > 0) begin
            void'(q_bit.pop_front());
            void'(q_last.pop_front());
        end
        if (!rst) begin
            q_bit.delete();
            q_last.delete();
        end else if (acc) begin
            acc_cnt++;
            for (int i = 0; i < FL8; i++) begin
                q_bit.push_back(frame_bit(32'(d), 8, 1'b1, i));
                q_last.push_back(i == FL8 - 1);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q_bit.size() > 0; i++) step(1'b0, 8'( 8'($urandom)));
        step(1'b0, 8'h00);
    endtask

    function automatic int count_hits();
        logic [3:0] hist;
        int n;
        hist = 4'b0000; n = 0;
        for (int i = 0; i < obs.size(); i++) begin
            hist = {hist[2:0], obs[i]};
            if (i >= 3 && hist == 4'b1010) n++;
        end
        return n;
    endfunction

    initial begin
        logic [31:0] got_v, exp_v;
        logic [3:0]  hist4;
        int          hit_at;

        clk = 1'b0; rst = 1'b1;
        d8_valid = 1'b0; d8_data = 8'h00; d4_valid = 1'b0; d4_data = 4'h0;
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset held while a word is offered
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF);
        d8_valid = 1'b0;
        rst = 1'b1;
        #1 check_val("ready_after_release", 32'(d8_ready), 32'h1);
        for (int i = 0; i < 2; i++) step(1'b0, 8'hFF);

        // Single word A5
        obs.delete();
        step(1'b1, 8'hA5);
        drain();
        check_val("a5_len", 32'(obs.size()), 32'(FL8));
        got_v = 32'h0;
        for (int i = 0; i < obs.size() && i < 8; i++) got_v = {got_v[30:0], obs[i]};
        check_val("a5_bits", got_v, 32'h0000_00A5);

        // Back-to-back 0A then A0 with load_valid held high
        obs.delete();
        acc_cnt = 0;
        step(1'b1, 8'h0A);
        for (int i = 0; i < 40 && acc_cnt < 2; i++) step(1'b1, 8'hA0);
        check_val("b2b_accepts", 32'(acc_cnt), 32'd2);
        drain();
        check_val("b2b_len", 32'(obs.size()), 32'(2 * FL8));
        got_v = 32'h0; exp_v = 32'h0;
        for (int i = 0; i < obs.size(); i++) got_v = {got_v[30:0], obs[i]};
        for (int i = 0; i < FL8; i++) exp_v = {exp_v[30:0], frame_bit(32'h0A, 8, 1'b1, i)};
        for (int i = 0; i < FL8; i++) exp_v = {exp_v[30:0], frame_bit(32'hA0, 8, 1'b1, i)};
        check_val("b2b_stream", got_v, exp_v);
        check_val("b2b_hits", 32'(count_hits()), 32'(HITS_EXP));

        // Random traffic
        for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 8'($urandom));
        drain();

        // Reset in the middle of a word of ones
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b0;
        #1;
        check_val("midrst_valid", 32'(d8_bv), 32'h0);
        check_val("midrst_x", 32'(d8_x), 32'(IDLE));
        check_val("midrst_last", 32'(d8_last), 32'h0);
        check_val("midrst_ready", 32'(d8_ready), 32'h0);
        q_bit.delete(); q_last.delete();
        step(1'b0, 8'h00);
        rst = 1'b1;
        #1 check_val("midrst_ready_rel", 32'(d8_ready), 32'h1);
        obs.delete();
        for (int i = 0; i < FL8 + 2; i++) step(1'b0, 8'h00);
        check_val("midrst_residual", 32'(obs.size()), 32'd0);

        // LSB-first 4-bit instance with 0101
        d4_valid = 1'b1;
        d4_data  = 4'b0101;
        check_val("d4_ready", 32'(d4_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        d4_valid = 1'b0;
        hist4 = 4'b0000;
        hit_at = -1;
        for (int i = 0; i < FL4; i++) begin
            check_val("d4_valid", 32'(d4_bv), 32'h1);
            check_val("d4_x", 32'(d4_x), 32'(frame_bit(32'h5, 4, 1'b0, i)));
            check_val("d4_last", 32'(d4_last), 32'(i == FL4 - 1));
            hist4 = {hist4[2:0], d4_x};
            if (i >= 3 && hist4 == 4'b1010 && hit_at < 0) hit_at = i;
            @(posedge clk);
            @(negedge clk);
        end
        check_val("d4_idle", 32'(d4_bv), 32'h0);
        check_val("d4_hit_pos", 32'(hit_at), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
